// File: rtl/voice_allocator.sv
// voice_allocator: assigns incoming MIDI note events to synth voices.
//
// An accepted event is latched, then every voice is examined one per clock
// (fixed VOICES-cycle scan). Note-ons go to a voice already playing the same
// key, else the lowest free idle voice, else the oldest voice. Note-offs
// release the voice playing the key, if there is one.
//
// Optional feature: define SUSTAIN_PEDAL_EN to add the sustain input. While
// sustain is high, note-offs only mark voices as sustained. A falling sustain
// edge releases every sustained voice.
//
// Ports
//   OSC_CLK      clock; all state changes on its rising edge
//   iRST         asynchronous active-high reset
//   sustain      sustain pedal level (SUSTAIN_PEDAL_EN only)
//   midi_valid   event strobe; accepted when midi_ready is high
//   midi_ready   high only while idle
//   midi_note_on 1 = note-on, 0 = note-off (a note-on with zero velocity is a note-off)
//   midi_key     key number
//   midi_vel     velocity
//   voice_free   per-voice envelope-idle flags, sampled only while scanning
//   keys_on      per-voice gate
//   note_on      new-note strobe, held for ON_HOLD cycles
//   cur_key_adr  voice index of the last processed event
//   cur_key_val  key of the last note-on
//   cur_vel_on   velocity of the last note-on
//   cur_vel_off  velocity of the last note-off
module voice_allocator #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3,
  parameter int unsigned ON_HOLD = 64
) (
  input  logic               OSC_CLK,
  input  logic               iRST,
`ifdef SUSTAIN_PEDAL_EN
  input  logic               sustain,
`endif
  input  logic               midi_valid,
  output logic               midi_ready,
  input  logic               midi_note_on,
  input  logic [6:0]         midi_key,
  input  logic [6:0]         midi_vel,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);

  localparam int unsigned        HoldW = $clog2(ON_HOLD + 1);
  localparam logic [V_WIDTH-1:0] LastV = V_WIDTH'(VOICES - 1);
  localparam logic [HoldW-1:0]   LastH = HoldW'(ON_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StScan, StEmitOn, StEmitOff} state_e;

  state_e              r_state;
  logic                r_ready;
  logic [6:0]          r_key;
  logic [6:0]          r_vel;
  logic                r_is_on;
  logic [V_WIDTH-1:0]  r_scan_idx;
  logic                r_match_hit;
  logic [V_WIDTH-1:0]  r_match_idx;
  logic                r_free_hit;
  logic [V_WIDTH-1:0]  r_free_idx;
  logic [V_WIDTH-1:0]  r_old_idx;
  logic [V_WIDTH-1:0]  r_old_age;
  logic [HoldW-1:0]    r_hold_cnt;
  logic [VOICES-1:0]   r_keys_on;
  logic [6:0]          r_voice_key [VOICES];
  logic [V_WIDTH-1:0]  r_age [VOICES];
  logic                r_note_on;
  logic [V_WIDTH-1:0]  r_adr;
  logic [7:0]          r_kval;
  logic [7:0]          r_von;
  logic [7:0]          r_voff;
`ifdef SUSTAIN_PEDAL_EN
  logic                r_sus_q;
  logic [VOICES-1:0]   r_sustained;
`endif

  // Running scan results with the voice under examination folded in.
  logic                w_match_hit;
  logic [V_WIDTH-1:0]  w_match_idx;
  logic                w_free_hit;
  logic [V_WIDTH-1:0]  w_free_idx;
  logic [V_WIDTH-1:0]  w_old_idx;
  logic [V_WIDTH-1:0]  w_old_age;
  logic [V_WIDTH-1:0]  w_sel;

  always_comb begin
    w_match_hit = r_match_hit;
    w_match_idx = r_match_idx;
    if (!r_match_hit && r_keys_on[r_scan_idx] && (r_voice_key[r_scan_idx] == r_key)) begin
      w_match_hit = 1'b1;
      w_match_idx = r_scan_idx;
    end
    w_free_hit = r_free_hit;
    w_free_idx = r_free_idx;
    if (!r_free_hit && voice_free[r_scan_idx] && !r_keys_on[r_scan_idx]) begin
      w_free_hit = 1'b1;
      w_free_idx = r_scan_idx;
    end
    // Strict compare keeps the lowest index on equal ages.
    w_old_idx = r_old_idx;
    w_old_age = r_old_age;
    if (r_age[r_scan_idx] > r_old_age) begin
      w_old_idx = r_scan_idx;
      w_old_age = r_age[r_scan_idx];
    end
    if (w_match_hit) begin
      w_sel = w_match_idx;
    end else if (w_free_hit) begin
      w_sel = w_free_idx;
    end else begin
      w_sel = w_old_idx;
    end
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= StIdle;
      r_ready     <= 1'b0;
      r_key       <= '0;
      r_vel       <= '0;
      r_is_on     <= 1'b0;
      r_scan_idx  <= '0;
      r_match_hit <= 1'b0;
      r_match_idx <= '0;
      r_free_hit  <= 1'b0;
      r_free_idx  <= '0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
      r_hold_cnt  <= '0;
      r_keys_on   <= '0;
      r_note_on   <= 1'b0;
      r_adr       <= '0;
      r_kval      <= '0;
      r_von       <= '0;
      r_voff      <= '0;
      for (int i = 0; i < int'(VOICES); i++) begin
        r_voice_key[i] <= '0;
        r_age[i]       <= '0;
      end
`ifdef SUSTAIN_PEDAL_EN
      r_sus_q     <= 1'b0;
      r_sustained <= '0;
`endif
    end else begin
`ifdef SUSTAIN_PEDAL_EN
      // Pedal release comes first so a same-cycle note-on still wins its voice.
      r_sus_q <= sustain;
      if (r_sus_q && !sustain) begin
        r_keys_on   <= r_keys_on & ~r_sustained;
        r_sustained <= '0;
      end
`endif
      unique case (r_state)
        StIdle: begin
          if (midi_valid && r_ready) begin
            r_ready     <= 1'b0;
            r_key       <= midi_key;
            r_vel       <= midi_vel;
            r_is_on     <= midi_note_on && (midi_vel != 7'd0);
            r_scan_idx  <= '0;
            r_match_hit <= 1'b0;
            r_match_idx <= '0;
            r_free_hit  <= 1'b0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
            r_old_age   <= '0;
            r_state     <= StScan;
          end else begin
            r_ready <= 1'b1;
          end
        end
        StScan: begin
          r_match_hit <= w_match_hit;
          r_match_idx <= w_match_idx;
          r_free_hit  <= w_free_hit;
          r_free_idx  <= w_free_idx;
          r_old_idx   <= w_old_idx;
          r_old_age   <= w_old_age;
          r_scan_idx  <= r_scan_idx + 1'b1;
          if (r_scan_idx == LastV) begin
            if (r_is_on) begin
              r_keys_on[w_sel]   <= 1'b1;
              r_voice_key[w_sel] <= r_key;
              r_adr              <= w_sel;
              r_kval             <= {1'b0, r_key};
              r_von              <= {1'b0, r_vel};
              r_note_on          <= 1'b1;
              r_hold_cnt         <= '0;
              r_state            <= StEmitOn;
              for (int i = 0; i < int'(VOICES); i++) begin
                if (i == int'(w_sel)) begin
                  r_age[i] <= '0;
                end else if (r_age[i] != LastV) begin
                  r_age[i] <= r_age[i] + 1'b1;
                end
              end
`ifdef SUSTAIN_PEDAL_EN
              r_sustained[w_sel] <= 1'b0;
`endif
            end else if (w_match_hit) begin
`ifdef SUSTAIN_PEDAL_EN
              if (sustain) begin
                r_sustained[w_match_idx] <= 1'b1;
              end else begin
                r_keys_on[w_match_idx] <= 1'b0;
              end
`else
              r_keys_on[w_match_idx] <= 1'b0;
`endif
              r_adr   <= w_match_idx;
              r_voff  <= {1'b0, r_vel};
              r_state <= StEmitOff;
            end else begin
              r_ready <= 1'b1;
              r_state <= StIdle;
            end
          end
        end
        StEmitOn: begin
          if (r_hold_cnt == LastH) begin
            r_note_on <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        StEmitOff: begin
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign midi_ready  = r_ready;
  assign keys_on     = r_keys_on;
  assign note_on     = r_note_on;
  assign cur_key_adr = r_adr;
  assign cur_key_val = r_kval;
  assign cur_vel_on  = r_von;
  assign cur_vel_off = r_voff;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed table, hand-written reset/steal/sustain
// sequences, and random events checked against a behavioural voice model.
module tb_voice_allocator;

  localparam int VOICES = 8;
  localparam int VW     = 3;
  localparam int HOLD   = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          midi_valid = 1'b0;
  logic          midi_ready;
  logic          midi_note_on = 1'b0;
  logic [6:0]    midi_key = '0;
  logic [6:0]    midi_vel = '0;
  logic [7:0]    voice_free = 8'hFF;
  logic [7:0]    keys_on;
  logic          note_on;
  logic [VW-1:0] cur_key_adr;
  logic [7:0]    cur_key_val;
  logic [7:0]    cur_vel_on;
  logic [7:0]    cur_vel_off;
`ifdef SUSTAIN_PEDAL_EN
  logic          sustain = 1'b0;
`endif

  voice_allocator #(
    .VOICES  (VOICES),
    .V_WIDTH (VW),
    .ON_HOLD (HOLD)
  ) dut (
    .OSC_CLK      (clk),
    .iRST         (rst),
`ifdef SUSTAIN_PEDAL_EN
    .sustain      (sustain),
`endif
    .midi_valid   (midi_valid),
    .midi_ready   (midi_ready),
    .midi_note_on (midi_note_on),
    .midi_key     (midi_key),
    .midi_vel     (midi_vel),
    .voice_free   (voice_free),
    .keys_on      (keys_on),
    .note_on      (note_on),
    .cur_key_adr  (cur_key_adr),
    .cur_key_val  (cur_key_val),
    .cur_vel_on   (cur_vel_on),
    .cur_vel_off  (cur_vel_off)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a voice's age is the number of note-ons since it was
  // last assigned, capped at VOICES-1.
  bit m_on [VOICES];
  int m_key [VOICES];
  int m_stamp [VOICES];
  int m_cnt;
  int m_adr, m_kval, m_von, m_voff, m_lat, m_ncnt;

  function automatic int m_age(int i);
    int a;
    a = m_cnt - m_stamp[i];
    return (a > VOICES - 1) ? VOICES - 1 : a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_on[i] = 0;
      m_key[i] = 0;
      m_stamp[i] = 0;
    end
    m_cnt = 0;
    m_adr = 0; m_kval = 0; m_von = 0; m_voff = 0;
  endfunction

  function automatic void model_event(bit on, int key, int vel, logic [7:0] free);
    int v;
    int best;
    v = -1;
    best = -1;
    if (on && vel != 0) begin
      for (int i = 0; i < VOICES; i++) if (v < 0 && m_on[i] && m_key[i] == key) v = i;
      for (int i = 0; i < VOICES; i++) if (v < 0 && free[i] && !m_on[i]) v = i;
      if (v < 0) begin
        for (int i = 0; i < VOICES; i++) begin
          if (m_age(i) > best) begin
            best = m_age(i);
            v = i;
          end
        end
      end
      m_cnt++;
      m_stamp[v] = m_cnt;
      m_on[v] = 1;
      m_key[v] = key;
      m_adr = v; m_kval = key; m_von = vel;
      m_lat = VOICES + HOLD;
      m_ncnt = HOLD;
    end else begin
      for (int i = 0; i < VOICES; i++) if (v < 0 && m_on[i] && m_key[i] == key) v = i;
      m_ncnt = 0;
      if (v >= 0) begin
        m_on[v] = 0;
        m_adr = v; m_voff = vel;
        m_lat = VOICES + 1;
      end else begin
        m_lat = VOICES;
      end
    end
  endfunction

  function automatic logic [7:0] m_keys();
    logic [7:0] k;
    for (int i = 0; i < VOICES; i++) k[i] = m_on[i];
    return k;
  endfunction

  // Observed results of the last event.
  logic [7:0] a_keys;
  int a_adr, a_kval, a_von, a_voff, a_lat, a_ncnt;

  task automatic run_event(input bit on, input int key, input int vel, input logic [7:0] free);
    int n;
    n = 0;
    @(negedge clk);
    while (!midi_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!midi_ready) chk("ready_wait", 32'(midi_ready), 1);
    voice_free = free;
    midi_valid = 1'b1;
    midi_note_on = on;
    midi_key = 7'(key);
    midi_vel = 7'(vel);
    @(posedge clk);
    #1 midi_valid = 1'b0;
    a_lat = 0;
    a_ncnt = 0;
    do begin
      @(posedge clk);
      #1 a_lat++;
      // A strobe while busy must be dropped.
      if (a_lat == 3) begin
        midi_valid = 1'b1;
        midi_key = 7'd100;
        midi_vel = 7'd5;
      end
      if (a_lat == 4) midi_valid = 1'b0;
      if (a_lat == VOICES) begin
        a_keys = keys_on;
        a_adr = cur_key_adr;
        a_kval = cur_key_val;
        a_von = cur_vel_on;
        a_voff = cur_vel_off;
      end
      // Free flags outside the scan window must not matter.
      if (a_lat > VOICES) voice_free = 8'($urandom);
      if (note_on) a_ncnt++;
    end while (!midi_ready && a_lat < 400);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".keys_on"}, a_keys, m_keys());
    chk({tag, ".adr"}, a_adr, m_adr);
    chk({tag, ".key_val"}, a_kval, m_kval);
    chk({tag, ".vel_on"}, a_von, m_von);
    chk({tag, ".vel_off"}, a_voff, m_voff);
    chk({tag, ".latency"}, a_lat, m_lat);
    chk({tag, ".note_on_cycles"}, a_ncnt, m_ncnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst.keys_on", keys_on, 0);
    chk("rst.ready", midi_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst.ready_rise", midi_ready, 1);
    model_reset();
  endtask

  typedef struct {
    bit         on;
    int         key;
    int         vel;
    logic [7:0] free;
    logic [7:0] keys;
    int         adr;
    int         kval;
    int         von;
    int         voff;
    int         lat;
    int         ncnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         r_on;
    int         r_key, r_vel, n;
    logic [7:0] r_free;

    tbl[0] = '{1, 60, 100, 8'hFF, 8'h01, 0, 60, 100, 0,  72, 64};
    tbl[1] = '{1, 60, 90,  8'hFF, 8'h01, 0, 60, 90,  0,  72, 64};
    tbl[2] = '{1, 61, 50,  8'hFF, 8'h03, 1, 61, 50,  0,  72, 64};
    tbl[3] = '{0, 61, 40,  8'hFF, 8'h01, 1, 61, 50,  40, 9,  0};
    tbl[4] = '{0, 99, 33,  8'hFF, 8'h01, 1, 61, 50,  40, 8,  0};
    tbl[5] = '{1, 61, 70,  8'hFF, 8'h03, 1, 61, 70,  40, 72, 64};
    tbl[6] = '{1, 61, 0,   8'hFF, 8'h01, 1, 61, 70,  0,  9,  0};
    tbl[7] = '{1, 62, 10,  8'hF0, 8'h11, 4, 62, 10,  0,  72, 64};
    tbl[8] = '{1, 63, 11,  8'h00, 8'h15, 2, 63, 11,  0,  72, 64};

    // Reset state.
    #12;
    chk("reset.ready", midi_ready, 0);
    chk("reset.keys_on", keys_on, 0);
    chk("reset.note_on", note_on, 0);
    chk("reset.adr", cur_key_adr, 0);
    chk("reset.key_val", cur_key_val, 0);
    chk("reset.vel_on", cur_vel_on, 0);
    chk("reset.vel_off", cur_vel_off, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("release.ready_low", midi_ready, 0);
    @(posedge clk);
    #1 chk("release.ready_rise", midi_ready, 1);
    model_reset();

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_event(tbl[i].on, tbl[i].key, tbl[i].vel, tbl[i].free);
      chk($sformatf("tbl%0d.keys_on", i), a_keys, tbl[i].keys);
      chk($sformatf("tbl%0d.adr", i), a_adr, tbl[i].adr);
      chk($sformatf("tbl%0d.key_val", i), a_kval, tbl[i].kval);
      chk($sformatf("tbl%0d.vel_on", i), a_von, tbl[i].von);
      chk($sformatf("tbl%0d.vel_off", i), a_voff, tbl[i].voff);
      chk($sformatf("tbl%0d.latency", i), a_lat, tbl[i].lat);
      chk($sformatf("tbl%0d.note_on_cycles", i), a_ncnt, tbl[i].ncnt);
    end

    // Fill all eight voices, then steal the oldest.
    do_reset();
    for (int k = 60; k < 68; k++) begin
      run_event(1, k, 100, 8'hFF);
      model_event(1, k, 100, 8'hFF);
      compare_model($sformatf("fill%0d", k));
    end
    run_event(1, 72, 55, 8'hFF);
    model_event(1, 72, 55, 8'hFF);
    compare_model("steal");
    chk("steal.adr_const", a_adr, 0);
    chk("steal.keys_const", a_keys, 8'hFF);
    chk("steal.key_val_const", a_kval, 72);

    // Random events against the model.
    for (int k = 0; k < 40; k++) begin
      r_on = ($urandom_range(0, 9) < 7);
      r_key = $urandom_range(60, 71);
      r_vel = $urandom_range(0, 127);
      r_free = 8'($urandom);
      run_event(r_on, r_key, r_vel, r_free);
      model_event(r_on, r_key, r_vel, r_free);
      compare_model($sformatf("rnd%0d", k));
    end

    // Reset in the middle of the note_on hold.
    n = 0;
    @(negedge clk);
    while (!midi_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!midi_ready) chk("abort.ready_wait", 32'(midi_ready), 1);
    voice_free = 8'hFF;
    midi_valid = 1'b1;
    midi_note_on = 1'b1;
    midi_key = 7'd64;
    midi_vel = 7'd77;
    @(posedge clk);
    #1 midi_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 chk("abort.note_on_before", note_on, 1);
    rst = 1'b1;
    #1;
    chk("abort.note_on", note_on, 0);
    chk("abort.keys_on", keys_on, 0);
    chk("abort.ready", midi_ready, 0);
    chk("abort.adr", cur_key_adr, 0);
    chk("abort.key_val", cur_key_val, 0);
    chk("abort.vel_on", cur_vel_on, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort.ready_low", midi_ready, 0);
    @(posedge clk);
    #1 chk("abort.ready_rise", midi_ready, 1);
    model_reset();

`ifdef SUSTAIN_PEDAL_EN
    do_reset();
    run_event(1, 60, 100, 8'hFF);
    chk("sus.on_keys", a_keys, 8'h01);
    @(negedge clk);
    sustain = 1'b1;
    run_event(0, 60, 20, 8'hFF);
    chk("sus.off_keys", a_keys, 8'h01);
    chk("sus.off_latency", a_lat, 9);
    @(negedge clk);
    sustain = 1'b0;
    @(posedge clk);
    #1 chk("sus.release_keys", keys_on, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
